aia_imsic_file_ctrl: RTL and testbench

- Controller for the AIA interrupt files of one hart: M file (index 0), S file (index 1) and NrVSIntpFiles VS files (index 2 and up).
- Owns the per-file eip/eie/eidelivery/eithreshold state.
- A single shared update slot is arbitrated round-robin between incoming MSI writes and CSR indirect accesses (read/write/claim).
- Computes topei and the interrupt line per file; sits between the MSI bus slave and the CSR file.

---
 rtl/aia_pkg.sv | 46 ++++
 rtl/aia_topei_prienc.sv | 27 ++
 rtl/aia_imsic_file_ctrl.sv | 147 ++++++++++++++
 tb/tb_aia_imsic_file_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aia_pkg.sv
// Shared definitions for the IMSIC interrupt-file controller.
//   csr_op_e   : CSR indirect operation codes (3 is reserved and behaves as READ)
//   csr_addr_e : per-file register selector for CSR accesses
//   rr_e       : which requester received the most recent grant
//   FILE_*     : fixed file indices (M, S, first VS file)
//   TOPEI_*    : bit positions of the two topei copies in a claim response
package aia_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_CLAIM = 2'd2,
    CSR_RSVD  = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ADDR_EIDELIVERY  = 2'd0,
    ADDR_EITHRESHOLD = 2'd1,
    ADDR_EIP         = 2'd2,
    ADDR_EIE         = 2'd3
  } csr_addr_e;

  typedef enum logic {
    RR_MSI = 1'b0,
    RR_CSR = 1'b1
  } rr_e;

  localparam int FILE_M   = 0;
  localparam int FILE_S   = 1;
  localparam int FILE_VS0 = 2;

  localparam int TOPEI_HI_MSB = 26;
  localparam int TOPEI_HI_LSB = 16;
  localparam int TOPEI_LO_MSB = 10;
  localparam int TOPEI_LO_LSB = 0;

  // Claim response word: the identity is returned in both topei fields.
  function automatic logic [31:0] topei_word(input logic [10:0] id);
    logic [31:0] w;
    w = '0;
    w[TOPEI_HI_MSB:TOPEI_HI_LSB] = id;
    w[TOPEI_LO_MSB:TOPEI_LO_LSB] = id;
    return w;
  endfunction

endpackage

// File: rtl/aia_topei_prienc.sv
// Combinational topei priority encoder for one interrupt file.
//   eip, eie  : pending / enable vectors (bit 0 is never an identity)
//   threshold : 0 disables thresholding, else only identities below it count
//   topei     : lowest enabled pending identity that passes the threshold, or 0
module aia_topei_prienc
  import aia_pkg::*;
#(
  parameter int NrSourcesW = 5
) (
  input  logic [2**NrSourcesW-1:0] eip,
  input  logic [2**NrSourcesW-1:0] eie,
  input  logic [NrSourcesW-1:0]    threshold,
  output logic [NrSourcesW-1:0]    topei
);

  // Scan from the top down so the last hit (lowest identity) wins.
  always_comb begin
    topei = '0;
    for (int i = 2**NrSourcesW - 1; i >= 0; i--) begin
      if ((i != 0) && eip[i] && eie[i] &&
          ((threshold == '0) || (i < int'(threshold)))) begin
        topei = NrSourcesW'(i);
      end
    end
  end

endmodule

// File: rtl/aia_imsic_file_ctrl.sv
// AIA interrupt-file controller for one hart (M, S and VS files).
//   clk_i / rst_ni          : clock, synchronous active-low reset
//   msi_valid_i/ready_o     : MSI write handshake, sets eip[msi_id_i] of msi_file_i
//   csr_valid_i/ready_o     : CSR indirect access handshake (read/write/claim)
//   csr_op/file/addr/wdata  : CSR request fields
//   csr_rdata_o/rvalid_o    : one-cycle response, one cycle after the accept
//   topei_o / irq_o         : registered topei and interrupt line per file
// MSI and CSR requests share one update slot, granted round-robin.
module aia_imsic_file_ctrl
  import aia_pkg::*;
#(
  parameter int NrVSIntpFiles = 1,
  parameter int NrIntpFiles   = 2 + NrVSIntpFiles,
  parameter int NrSourcesW    = 5,
  parameter int FileW         = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              msi_valid_i,
  output logic                              msi_ready_o,
  input  logic [FileW-1:0]                  msi_file_i,
  input  logic [NrSourcesW-1:0]             msi_id_i,
  input  logic                              csr_valid_i,
  output logic                              csr_ready_o,
  input  logic [1:0]                        csr_op_i,
  input  logic [FileW-1:0]                  csr_file_i,
  input  logic [1:0]                        csr_addr_i,
  input  logic [31:0]                       csr_wdata_i,
  output logic [31:0]                       csr_rdata_o,
  output logic                              csr_rvalid_o,
  output logic [NrIntpFiles*NrSourcesW-1:0] topei_o,
  output logic [NrIntpFiles-1:0]            irq_o
);

  localparam int NrIds = 2**NrSourcesW;
  typedef logic [NrIds-1:0] vec_t;

  vec_t                  eip_reg [NrIntpFiles];
  vec_t                  eip_next[NrIntpFiles];
  vec_t                  eie_reg [NrIntpFiles];
  vec_t                  eie_next[NrIntpFiles];
  logic [NrSourcesW-1:0] eithreshold_reg [NrIntpFiles];
  logic [NrSourcesW-1:0] eithreshold_next[NrIntpFiles];
  logic [NrSourcesW-1:0] topei_reg [NrIntpFiles];
  logic [NrSourcesW-1:0] topei_next[NrIntpFiles];
  logic [NrIntpFiles-1:0] eidelivery_reg, eidelivery_next;
  logic [NrIntpFiles-1:0] irq_reg, irq_next;
  rr_e                    rr_last_reg, rr_last_next;
  logic                   rvalid_reg;
  logic [31:0]            rdata_reg, rdata_next;
  logic                   msi_grant, csr_grant;

  // On contention the requester that did not win last time is granted.
  assign msi_grant = rst_ni && msi_valid_i && (!csr_valid_i || (rr_last_reg == RR_CSR));
  assign csr_grant = rst_ni && csr_valid_i && (!msi_valid_i || (rr_last_reg == RR_MSI));
  assign msi_ready_o = msi_grant;
  assign csr_ready_o = csr_grant;

  always_comb begin
    rr_last_next    = rr_last_reg;
    if (msi_grant)      rr_last_next = RR_MSI;
    else if (csr_grant) rr_last_next = RR_CSR;

    rdata_next      = '0;
    eidelivery_next = eidelivery_reg;
    for (int f = 0; f < NrIntpFiles; f++) begin
      eip_next[f]         = eip_reg[f];
      eie_next[f]         = eie_reg[f];
      eithreshold_next[f] = eithreshold_reg[f];

      if (msi_grant && (msi_file_i == FileW'(f)) && (msi_id_i != '0)) begin
        eip_next[f][msi_id_i] = 1'b1;
      end

      if (csr_grant && (csr_file_i == FileW'(f))) begin
        if (csr_op_i == CSR_CLAIM) begin
          // topei_reg always reflects the current state, so it is the claim target.
          rdata_next = topei_word(11'(topei_reg[f]));
          if (topei_reg[f] != '0) begin
            eip_next[f][topei_reg[f]] = 1'b0;
          end
        end else begin
          case (csr_addr_i)
            ADDR_EIDELIVERY:  rdata_next = 32'(eidelivery_reg[f]);
            ADDR_EITHRESHOLD: rdata_next = 32'(eithreshold_reg[f]);
            ADDR_EIP:         rdata_next = 32'(eip_reg[f]);
            default:          rdata_next = 32'(eie_reg[f]);
          endcase
          if (csr_op_i == CSR_WRITE) begin
            case (csr_addr_i)
              ADDR_EIDELIVERY:  eidelivery_next[f]  = csr_wdata_i[0];
              ADDR_EITHRESHOLD: eithreshold_next[f] = csr_wdata_i[NrSourcesW-1:0];
              ADDR_EIP:         eip_next[f] = vec_t'(csr_wdata_i) & ~vec_t'(1);
              default:          eie_next[f] = vec_t'(csr_wdata_i) & ~vec_t'(1);
            endcase
          end
        end
      end
    end
  end

  // topei/irq are computed from the post-edge state so they track it with no lag.
  generate
    for (genvar gi = 0; gi < NrIntpFiles; gi++) begin : g_file
      aia_topei_prienc #(.NrSourcesW(NrSourcesW)) u_prienc (
        .eip       (eip_next[gi]),
        .eie       (eie_next[gi]),
        .threshold (eithreshold_next[gi]),
        .topei     (topei_next[gi])
      );
      assign irq_next[gi] = eidelivery_next[gi] && (topei_next[gi] != '0);
      assign topei_o[gi*NrSourcesW +: NrSourcesW] = topei_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int f = 0; f < NrIntpFiles; f++) begin
        eip_reg[f]         <= '0;
        eie_reg[f]         <= '0;
        eithreshold_reg[f] <= '0;
        topei_reg[f]       <= '0;
      end
      eidelivery_reg <= '0;
      irq_reg        <= '0;
      rr_last_reg    <= RR_CSR;
      rvalid_reg     <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      eip_reg         <= eip_next;
      eie_reg         <= eie_next;
      eithreshold_reg <= eithreshold_next;
      topei_reg       <= topei_next;
      eidelivery_reg  <= eidelivery_next;
      irq_reg         <= irq_next;
      rr_last_reg     <= rr_last_next;
      rvalid_reg      <= csr_grant;
      rdata_reg       <= rdata_next;
    end
  end

  // A response pending when reset asserts is dropped rather than presented.
  assign csr_rvalid_o = rvalid_reg && rst_ni;
  assign csr_rdata_o  = rst_ni ? rdata_reg : '0;
  assign irq_o        = irq_reg;

endmodule

// File: tb/tb_aia_imsic_file_ctrl.sv
module tb_aia_imsic_file_ctrl;

  localparam int NF = 3;
  localparam int SW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           msi_valid, msi_ready;
  logic [1:0]     msi_file;
  logic [SW-1:0]  msi_id;
  logic           csr_valid, csr_ready;
  logic [1:0]     csr_op, csr_file, csr_addr;
  logic [31:0]    csr_wdata, csr_rdata;
  logic           csr_rvalid;
  logic [NF*SW-1:0] topei;
  logic [NF-1:0]  irq;

  int vectors = 0;
  int miscompares = 0;

  aia_imsic_file_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .msi_valid_i(msi_valid), .msi_ready_o(msi_ready),
    .msi_file_i(msi_file), .msi_id_i(msi_id),
    .csr_valid_i(csr_valid), .csr_ready_o(csr_ready),
    .csr_op_i(csr_op), .csr_file_i(csr_file), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_rvalid_o(csr_rvalid),
    .topei_o(topei), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] top_of(input int f);
    return 32'(topei[f*SW +: SW]);
  endfunction

  // ---------------- behavioural model ----------------
  bit [31:0] m_eip[NF], m_eie[NF];
  bit        m_del[NF];
  bit [4:0]  m_thr[NF];
  bit        m_last_csr;
  bit        m_rvalid;
  bit [31:0] m_rdata;
  bit        model_ok = 1'b0;

  function automatic bit [4:0] m_top(input int f);
    for (int i = 1; i < 32; i++)
      if (m_eip[f][i] && m_eie[f][i] && (m_thr[f] == 0 || i < m_thr[f])) return 5'(i);
    return 5'd0;
  endfunction

  always @(negedge clk) begin : model
    bit mg, cg;
    bit [4:0] t;
    int f;
    if (model_ok) begin
      mg = rst_n && msi_valid && (!csr_valid || m_last_csr);
      cg = rst_n && csr_valid && (!msi_valid || !m_last_csr);
      chk("msi_ready", 32'(msi_ready), 32'(mg));
      chk("csr_ready", 32'(csr_ready), 32'(cg));
      chk("rvalid", 32'(csr_rvalid), 32'(m_rvalid && rst_n));
      if (m_rvalid && rst_n) chk("rdata", csr_rdata, m_rdata);
      for (int k = 0; k < NF; k++) begin
        chk($sformatf("topei[%0d]", k), top_of(k), 32'(m_top(k)));
        chk($sformatf("irq[%0d]", k), 32'(irq[k]), 32'(m_del[k] && m_top(k) != 0));
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (!rst_n) begin
      for (int k = 0; k < NF; k++) begin
        m_eip[k] = 0; m_eie[k] = 0; m_del[k] = 0; m_thr[k] = 0;
      end
      m_last_csr = 1'b1; m_rvalid = 1'b0; m_rdata = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      mg = msi_valid && (!csr_valid || m_last_csr);
      cg = csr_valid && (!msi_valid || !m_last_csr);
      m_rvalid = cg;
      m_rdata  = 0;
      if (mg) begin
        m_last_csr = 1'b0;
        if (int'(msi_file) < NF && msi_id != 0) m_eip[msi_file][msi_id] = 1'b1;
      end else if (cg) begin
        m_last_csr = 1'b1;
        f = int'(csr_file);
        if (f < NF) begin
          if (csr_op == 2) begin
            t = m_top(f);
            m_rdata = (32'(t) << 16) | 32'(t);
            if (t != 0) m_eip[f][t] = 1'b0;
          end else begin
            case (csr_addr)
              0: m_rdata = 32'(m_del[f]);
              1: m_rdata = 32'(m_thr[f]);
              2: m_rdata = m_eip[f];
              default: m_rdata = m_eie[f];
            endcase
            if (csr_op == 1) begin
              case (csr_addr)
                0: m_del[f] = csr_wdata[0];
                1: m_thr[f] = csr_wdata[4:0];
                2: m_eip[f] = csr_wdata & 32'hFFFF_FFFE;
                default: m_eie[f] = csr_wdata & 32'hFFFF_FFFE;
              endcase
            end
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_csr(input int op, input int f, input int a, input logic [31:0] wd);
    csr_valid = 1'b1; msi_valid = 1'b0;
    csr_op = 2'(op); csr_file = 2'(f); csr_addr = 2'(a); csr_wdata = wd;
    step();
    csr_valid = 1'b0;
    $display("csr op=%0d file=%0d addr=%0d wdata=0x%08h -> rvalid=%0b rdata=0x%08h",
             op, f, a, wd, csr_rvalid, csr_rdata);
  endtask

  task automatic do_msi(input int f, input int id);
    msi_valid = 1'b1; csr_valid = 1'b0;
    msi_file = 2'(f); msi_id = SW'(id);
    step();
    msi_valid = 1'b0;
    $display("msi file=%0d id=%0d -> topei=0x%04h irq=%b", f, id, topei, irq);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    msi_valid = 1'b1; msi_file = 2'd2; msi_id = 5'd1;
    csr_valid = 1'b1; csr_op = 2'd0; csr_file = 2'd0; csr_addr = 2'd3; csr_wdata = 0;

    // Reset held with both requesters valid.
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst msi_ready", 32'(msi_ready), 0);
      chk("rst csr_ready", 32'(csr_ready), 0);
      step();
      chk("rst topei", 32'(topei), 0);
      chk("rst irq", 32'(irq), 0);
      chk("rst rvalid", 32'(csr_rvalid), 0);
      $display("reset cycle %0d", k);
    end

    // Release: grants alternate starting with MSI.
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("arb msi_ready", 32'(msi_ready), 32'(k % 2 == 0));
      chk("arb csr_ready", 32'(csr_ready), 32'(k % 2 == 1));
      $display("arb cycle %0d msi_ready=%0b csr_ready=%0b", k, msi_ready, csr_ready);
      step();
      if (csr_rvalid) pulses++;
    end
    msi_valid = 1'b0; csr_valid = 1'b0;
    step();
    if (csr_rvalid) pulses++;
    chk("arb rvalid pulses", 32'(pulses), 2);

    // Delivery on file 1.
    do_csr(1, 1, 3, 32'h80);
    chk("wr eie rvalid", 32'(csr_rvalid), 1);
    chk("wr eie old", csr_rdata, 0);
    do_csr(1, 1, 0, 32'h1);
    chk("wr deliv old", csr_rdata, 0);
    do_msi(1, 7);
    chk("f1 topei", top_of(1), 7);
    chk("f1 irq", 32'(irq[1]), 1);

    // Threshold on file 0.
    do_msi(0, 3);
    do_msi(0, 9);
    do_csr(1, 0, 3, 32'h208);
    do_csr(1, 0, 0, 32'h1);
    do_csr(1, 0, 1, 32'd5);
    chk("thr5 topei", top_of(0), 3);
    chk("thr5 irq", 32'(irq[0]), 1);
    do_csr(1, 0, 1, 32'd3);
    chk("thr3 old", csr_rdata, 5);
    chk("thr3 topei", top_of(0), 0);
    chk("thr3 irq", 32'(irq[0]), 0);
    do_csr(1, 0, 1, 32'd0);
    chk("thr0 old", csr_rdata, 3);
    chk("thr0 topei", top_of(0), 3);

    // Claims on file 0.
    do_csr(2, 0, 1, 0);
    chk("claim1", csr_rdata, 32'h0003_0003);
    chk("claim1 topei", top_of(0), 9);
    do_csr(2, 0, 2, 0);
    chk("claim2", csr_rdata, 32'h0009_0009);
    chk("claim2 topei", top_of(0), 0);
    do_csr(2, 0, 0, 0);
    chk("claim3 rvalid", 32'(csr_rvalid), 1);
    chk("claim3", csr_rdata, 0);

    // Illegal requests.
    do_msi(0, 0);
    do_msi(3, 5);
    do_csr(0, 0, 2, 0);
    chk("eip f0", csr_rdata, 0);
    do_csr(0, 1, 2, 0);
    chk("eip f1", csr_rdata, 32'h80);
    do_csr(0, 2, 2, 0);
    chk("eip f2", csr_rdata, 32'h2);
    do_csr(0, 3, 2, 0);
    chk("oor rvalid", 32'(csr_rvalid), 1);
    chk("oor rdata", csr_rdata, 0);
    do_csr(3, 1, 3, 0);
    chk("rsvd op reads", csr_rdata, 32'h80);

    // Reset right after a CSR accept.
    do_csr(1, 1, 3, 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("midrst rvalid", 32'(csr_rvalid), 0);
    step();
    rst_n = 1'b1;
    chk("midrst topei", 32'(topei), 0);
    chk("midrst irq", 32'(irq), 0);
    chk("midrst rvalid2", 32'(csr_rvalid), 0);
    do_csr(0, 1, 3, 0);
    chk("midrst eie", csr_rdata, 0);
    do_csr(0, 1, 0, 0);
    chk("midrst deliv", csr_rdata, 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
